// File: rtl/openmips_pkg.sv
// -----------------------------------------------------------------------------
// openmips_pkg
// Shared encodings for the openMIPS execute stage: result-class selectors
// (SEL_*), operation codes (OP_*), the divider state enum, and a conditional
// two's-complement helper used by the divider for sign handling.
// -----------------------------------------------------------------------------
package openmips_pkg;

    localparam int DATA_W = 32;

    // Result class selectors
    localparam logic [2:0] SEL_NOP   = 3'd0;
    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_ARITH = 3'd3;
    localparam logic [2:0] SEL_MOVE  = 3'd4;
    localparam logic [2:0] SEL_DIV   = 3'd5;

    // Operation codes
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_MFHI = 8'h10;
    localparam logic [7:0] OP_MFLO = 8'h12;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_ZERO = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v,
                                                      input logic              neg);
        logic [DATA_W-1:0] r;
        if (neg) begin
            r = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/ex_div.sv
// -----------------------------------------------------------------------------
// ex_div
// Multi-cycle restoring radix-2 divider for DIV/DIVU. Operands are captured
// as magnitudes when the divide starts; one quotient bit is produced per BUSY
// cycle and signs are reapplied on the outputs.
// Ports:
//   clk, rst_          clock, asynchronous active-low reset
//   flush              abort: next state IDLE, busy_o/done_o suppressed
//   start              a DIV-class instruction is present in EX
//   signed_op          1 = DIV (signed), 0 = DIVU
//   op_a, op_b         dividend, divisor
//   busy_o             pipeline freeze request
//   done_o             one-cycle strobe; quo_o/rem_o valid for HI/LO write
//   quo_o, rem_o       signed-corrected quotient and remainder
// -----------------------------------------------------------------------------
module ex_div
    import openmips_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          flush,
    input  logic          start,
    input  logic          signed_op,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] quo_o,
    output logic [DW-1:0] rem_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DW - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    quo_q, quo_d;     // dividend shifts out, quotient shifts in
    logic [DW-1:0]    rem_q, rem_d;     // partial remainder
    logic [DW-1:0]    dvsr_q, dvsr_d;   // divisor magnitude
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic             a_neg_s, b_neg_s, div_zero_s;
    logic [DW:0]      trial_s, diff_s;

    assign a_neg_s    = signed_op & op_a[DW-1];
    assign b_neg_s    = signed_op & op_b[DW-1];
    assign div_zero_s = (op_b == {DW{1'b0}});
    // Partial remainder is always below the divisor, so DW+1 bits hold the trial.
    assign trial_s    = {rem_q, quo_q[DW-1]};
    assign diff_s     = trial_s - {1'b0, dvsr_q};

    // State register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins from every state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        state_d = div_zero_s ? DIV_ZERO : DIV_BUSY;
                    end else begin
                        state_d = DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = DIV_DONE;
                    end else begin
                        state_d = DIV_BUSY;
                    end
                end
                DIV_ZERO: state_d = DIV_DONE;
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    // Datapath next values: operand capture on start, one iteration per BUSY cycle
    always_comb begin
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if ((state_q == DIV_IDLE) && start && !flush) begin
            cnt_d = {CNT_W{1'b0}};
            if (div_zero_s) begin
                // Fixed divide-by-zero result, carried unsigned to the outputs
                quo_d     = {DW{1'b1}};
                rem_d     = op_a;
                dvsr_d    = op_b;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
            end else begin
                quo_d     = cond_negate(op_a, a_neg_s);
                rem_d     = {DW{1'b0}};
                dvsr_d    = cond_negate(op_b, b_neg_s);
                neg_quo_d = a_neg_s ^ b_neg_s;
                neg_rem_d = a_neg_s;
            end
        end else if (state_q == DIV_BUSY) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (!diff_s[DW]) begin
                rem_d = diff_s[DW-1:0];
                quo_d = {quo_q[DW-2:0], 1'b1};
            end else begin
                rem_d = trial_s[DW-1:0];
                quo_d = {quo_q[DW-2:0], 1'b0};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q     <= {CNT_W{1'b0}};
            quo_q     <= {DW{1'b0}};
            rem_q     <= {DW{1'b0}};
            dvsr_q    <= {DW{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Outputs: stall covers the start cycle too, and never asserts in reset
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        if (rst_ && !flush) begin
            case (state_q)
                DIV_IDLE: busy_o = start;
                DIV_BUSY: busy_o = 1'b1;
                DIV_ZERO: busy_o = 1'b1;
                DIV_DONE: done_o = 1'b1;
                default:  busy_o = 1'b0;
            endcase
        end else begin
            busy_o = 1'b0;
        end
        quo_o = cond_negate(quo_q, neg_quo_q);
        rem_o = cond_negate(rem_q, neg_rem_q);
    end

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage of the openMIPS pipeline. Single-cycle ALU result mux for
// logic/shift/arith/move ops, HI/LO registers, and a multi-cycle divider that
// freezes the front of the pipeline via stall_req.
// Ports:
//   clk, rst_                  clock, asynchronous active-low reset
//   ex_alu_op, ex_alu_sel      operation code and result class
//   ex_reg0, ex_reg1           operands (ex_reg1[4:0] is the shift amount)
//   ex_wd, ex_wreg             destination index / write enable
//   flush                      abort any in-flight divide
//   mem_wd, mem_wreg, mem_wdata  write-back triple to EX/MEM
//   stall_req                  freeze request while dividing
//   hi_o, lo_o                 current HI/LO
// -----------------------------------------------------------------------------
module ex_stage
    import openmips_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic [7:0]    ex_alu_op,
    input  logic [2:0]    ex_alu_sel,
    input  logic [DW-1:0] ex_reg0,
    input  logic [DW-1:0] ex_reg1,
    input  logic [4:0]    ex_wd,
    input  logic          ex_wreg,
    input  logic          flush,
    output logic [4:0]    mem_wd,
    output logic          mem_wreg,
    output logic [DW-1:0] mem_wdata,
    output logic          stall_req,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DW-1:0] result_s, quo_s, rem_s;
    logic          valid_s, div_done_s, div_busy_s;
    logic [4:0]    shamt_s;

    assign shamt_s = ex_reg1[4:0];

    ex_div #(.DW(DW), .CNT_W(CNT_W)) u_div (
        .clk       (clk),
        .rst_      (rst_),
        .flush     (flush),
        .start     (ex_alu_sel == SEL_DIV),
        .signed_op (ex_alu_op == OP_DIV),
        .op_a      (ex_reg0),
        .op_b      (ex_reg1),
        .busy_o    (div_busy_s),
        .done_o    (div_done_s),
        .quo_o     (quo_s),
        .rem_o     (rem_s)
    );

    // Result mux; valid_s drops for NOP, DIV and unrecognised opcodes
    always_comb begin
        result_s = {DW{1'b0}};
        valid_s  = 1'b1;
        case (ex_alu_sel)
            SEL_LOGIC: begin
                case (ex_alu_op)
                    OP_OR:   result_s = ex_reg0 | ex_reg1;
                    OP_AND:  result_s = ex_reg0 & ex_reg1;
                    OP_XOR:  result_s = ex_reg0 ^ ex_reg1;
                    OP_NOR:  result_s = ~(ex_reg0 | ex_reg1);
                    default: valid_s  = 1'b0;
                endcase
            end
            SEL_SHIFT: begin
                case (ex_alu_op)
                    OP_SLL:  result_s = ex_reg0 << shamt_s;
                    OP_SRL:  result_s = ex_reg0 >> shamt_s;
                    OP_SRA:  result_s = $unsigned($signed(ex_reg0) >>> shamt_s);
                    default: valid_s  = 1'b0;
                endcase
            end
            SEL_ARITH: begin
                case (ex_alu_op)
                    OP_ADDU: result_s = ex_reg0 + ex_reg1;
                    OP_SUBU: result_s = ex_reg0 - ex_reg1;
                    OP_SLT:  result_s = {{(DW-1){1'b0}}, ($signed(ex_reg0) < $signed(ex_reg1))};
                    OP_SLTU: result_s = {{(DW-1){1'b0}}, (ex_reg0 < ex_reg1)};
                    default: valid_s  = 1'b0;
                endcase
            end
            SEL_MOVE: begin
                case (ex_alu_op)
                    OP_MFHI: result_s = hi_q;
                    OP_MFLO: result_s = lo_q;
                    default: valid_s  = 1'b0;
                endcase
            end
            default: valid_s = 1'b0;
        endcase
    end

    // Write-back triple is forced to zero while reset is asserted
    always_comb begin
        if (rst_) begin
            mem_wd    = ex_wd;
            mem_wreg  = ex_wreg & valid_s;
            mem_wdata = valid_s ? result_s : {DW{1'b0}};
        end else begin
            mem_wd    = 5'd0;
            mem_wreg  = 1'b0;
            mem_wdata = {DW{1'b0}};
        end
    end

    // HI/LO next values: only a completed divide writes them
    always_comb begin
        if (div_done_s) begin
            hi_d = rem_s;
            lo_d = quo_s;
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // HI/LO registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            hi_q <= {DW{1'b0}};
            lo_q <= {DW{1'b0}};
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign stall_req = div_busy_s;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage
// Directed self-checking bench for ex_stage. Inputs change 1 time unit after
// the rising edge; outputs are sampled 1 unit after that.
// -----------------------------------------------------------------------------
module tb_ex_stage;
    import openmips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_;
    logic [7:0]  ex_alu_op;
    logic [2:0]  ex_alu_sel;
    logic [31:0] ex_reg0, ex_reg1;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stall_req;
    logic [31:0] hi_o, lo_o;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk        (clk),
        .rst_       (rst_),
        .ex_alu_op  (ex_alu_op),
        .ex_alu_sel (ex_alu_sel),
        .ex_reg0    (ex_reg0),
        .ex_reg1    (ex_reg1),
        .ex_wd      (ex_wd),
        .ex_wreg    (ex_wreg),
        .flush      (flush),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .stall_req  (stall_req),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu(input string tag, input logic [2:0] sel, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_d, input logic exp_w);
        @(posedge clk); #1;
        ex_alu_sel = sel; ex_alu_op = op; ex_reg0 = a; ex_reg1 = b;
        ex_wd = 5'd9; ex_wreg = 1'b1;
        #1;
        chk({tag, "_wdata"}, mem_wdata, exp_d);
        chk({tag, "_wreg"}, {31'd0, mem_wreg}, {31'd0, exp_w});
    endtask

    task automatic do_div(input string tag, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int exp_stall,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit wait_edge);
        int   n;
        logic wr_seen;
        if (wait_edge) begin
            @(posedge clk); #1;
        end
        ex_alu_sel = SEL_DIV; ex_alu_op = op; ex_reg0 = a; ex_reg1 = b;
        ex_wd = 5'd3; ex_wreg = 1'b1;
        #1;
        n = 0;
        wr_seen = 1'b0;
        while (stall_req === 1'b1 && n < 100) begin
            n++;
            wr_seen = wr_seen | mem_wreg;
            @(posedge clk); #2;
        end
        wr_seen = wr_seen | mem_wreg;
        chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        chk({tag, "_wreg_low"}, {31'd0, wr_seen}, 32'd0);
        @(posedge clk); #2;
        chk({tag, "_hi"}, hi_o, exp_hi);
        chk({tag, "_lo"}, lo_o, exp_lo);
        ex_alu_sel = SEL_NOP; ex_alu_op = 8'h00;
    endtask

    initial begin
        rst_ = 1'b0; flush = 1'b0;
        ex_alu_sel = SEL_ARITH; ex_alu_op = OP_ADDU;
        ex_reg0 = 32'd1; ex_reg1 = 32'd2; ex_wd = 5'd7; ex_wreg = 1'b1;

        // Outputs held at zero during reset
        #12;
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wreg", {31'd0, mem_wreg}, 32'd0);
        chk("rst_wd", {27'd0, mem_wd}, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        ex_alu_sel = SEL_DIV; ex_alu_op = OP_DIVU; ex_reg1 = 32'd7;
        #1;
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        ex_alu_sel = SEL_NOP;
        #10 rst_ = 1'b1;

        // Single-cycle ops
        alu("addu_wrap", SEL_ARITH, OP_ADDU, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1);
        chk("addu_wd", {27'd0, mem_wd}, 32'd9);
        alu("subu_wrap", SEL_ARITH, OP_SUBU, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1);
        alu("slt", SEL_ARITH, OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
        alu("sltu", SEL_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        alu("sra", SEL_SHIFT, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b1);
        alu("srl", SEL_SHIFT, OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b1);
        alu("sll", SEL_SHIFT, OP_SLL, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b1);
        alu("or", SEL_LOGIC, OP_OR, 32'h0F0F_0000, 32'h00FF_00FF, 32'h0FFF_00FF, 1'b1);
        alu("and", SEL_LOGIC, OP_AND, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h000F_000F, 1'b1);
        alu("xor", SEL_LOGIC, OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b1);
        alu("nor", SEL_LOGIC, OP_NOR, 32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000, 1'b1);
        alu("bad_op", SEL_LOGIC, 8'h99, 32'h1234_5678, 32'h1111_1111, 32'd0, 1'b0);
        alu("nop", SEL_NOP, OP_ADDU, 32'h1234_5678, 32'h1111_1111, 32'd0, 1'b0);

        // Divides
        do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b1);
        alu("mflo", SEL_MOVE, OP_MFLO, 32'd0, 32'd0, 32'd14, 1'b1);
        alu("mfhi", SEL_MOVE, OP_MFHI, 32'd0, 32'd0, 32'd2, 1'b1);
        do_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        do_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0);
        do_div("div_5_0", OP_DIV, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF, 1'b1);

        // Flush mid-divide
        @(posedge clk); #1;
        ex_alu_sel = SEL_DIV; ex_alu_op = OP_DIVU; ex_reg0 = 32'd1000; ex_reg1 = 32'd3;
        repeat (21) @(posedge clk);
        #2;
        chk("flush_pre_stall", {31'd0, stall_req}, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; ex_alu_sel = SEL_NOP;
        #1;
        chk("flush_idle", {31'd0, stall_req}, 32'd0);
        chk("flush_hi", hi_o, 32'd5);
        chk("flush_lo", lo_o, 32'hFFFF_FFFF);
        do_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 33, 32'd0, 32'd3, 1'b1);
        do_div("divu_20_6", OP_DIVU, 32'd20, 32'd6, 33, 32'd2, 32'd3, 1'b0);

        // Reset mid-divide
        @(posedge clk); #1;
        ex_alu_sel = SEL_DIV; ex_alu_op = OP_DIVU; ex_reg0 = 32'd100; ex_reg1 = 32'd7;
        repeat (11) @(posedge clk);
        #2;
        chk("mrst_pre_stall", {31'd0, stall_req}, 32'd1);
        #1 rst_ = 1'b0;
        #1;
        chk("mrst_stall", {31'd0, stall_req}, 32'd0);
        chk("mrst_hi", hi_o, 32'd0);
        chk("mrst_lo", lo_o, 32'd0);
        ex_alu_sel = SEL_NOP;
        @(posedge clk); #1 rst_ = 1'b1;
        @(posedge clk); #2;
        chk("mrst_idle", {31'd0, stall_req}, 32'd0);
        do_div("post_rst_divu", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
